// File: rtl/pixel_seq_ctrl_if.sv
// Control/status bundle between the pixel sequencer and its host/analog front end.
// The sequencer connects as slave; whoever drives start/abort/cmp uses master.
interface pixel_seq_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             start_i;
    logic             abort_i;
    logic [11:0]      pd_mask_i;
    logic [15:0]      t_int_i;
    logic             cmp_i;

    logic             sw1_o;
    logic             sw2_o;
    logic             sh_o;
    logic             sh_cmp_o;
    logic             sh_rst_o;
    logic [11:0]      pd_a_o;
    logic [11:0]      pd_b_o;
    logic [4:0]       tg_sel_o;
    logic [CNT_W-1:0] data_o;
    logic [3:0]       pd_idx_o;
    logic             data_valid_o;
    logic             done_o;
    logic             busy_o;

    modport slave (
        input  start_i, abort_i, pd_mask_i, t_int_i, cmp_i,
        output sw1_o, sw2_o, sh_o, sh_cmp_o, sh_rst_o, pd_a_o, pd_b_o,
               tg_sel_o, data_o, pd_idx_o, data_valid_o, done_o, busy_o
    );

    modport master (
        output start_i, abort_i, pd_mask_i, t_int_i, cmp_i,
        input  sw1_o, sw2_o, sh_o, sh_cmp_o, sh_rst_o, pd_a_o, pd_b_o,
               tg_sel_o, data_o, pd_idx_o, data_valid_o, done_o, busy_o
    );
endinterface

// File: rtl/pixel_seq_ctrl.sv
// Frame-scan sequencer for a 12-photodiode pixel: reset, integrate, sample-and-hold
// and single-slope conversion of each enabled photodiode in ascending index order.
module pixel_seq_ctrl #(
    parameter int unsigned T_RST = 4,
    parameter int unsigned T_SH  = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    pixel_seq_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        RST,
        INT,
        SAMPLE,
        CONV,
        OUT,
        NEXT,
        DONE
    } state_t;

    localparam logic [15:0]      RST_LAST = 16'(T_RST - 1);
    localparam logic [15:0]      SH_LAST  = 16'(T_SH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [4:0] TG_OTA_OUT  = 5'b00001;
    localparam logic [4:0] TG_CMP_OUT  = 5'b00100;
    localparam logic [4:0] TG_OTA_SH   = 5'b01000;
    localparam logic [4:0] TG_VREF_CMP = 5'b10000;

    state_t           state_q, state_d;
    logic [15:0]      phase_cnt_q;
    logic [CNT_W-1:0] conv_cnt_q;
    logic [CNT_W-1:0] data_q;
    logic [3:0]       idx_q;
    logic [11:0]      mask_q;
    logic [15:0]      t_int_q;
    logic [15:0]      int_last;

    logic [11:0]      scan_mask;
    logic [3:0]       scan_from;
    logic             hit;
    logic [3:0]       hit_idx;

    // Lowest set mask bit at or above 'from'; bit 4 of the result flags a hit.
    function automatic logic [4:0] first_set(input logic [11:0] m, input logic [3:0] from);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 11; i >= 0; i--) begin
            if (m[i] && (i >= int'(from))) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

    // A zero integration length still spends one cycle in INT.
    assign int_last = (t_int_q == 16'd0) ? 16'd0 : t_int_q - 16'd1;

    // From IDLE the search runs over the live mask; from NEXT over the latched one,
    // starting above the current pixel so index 11 has nowhere to wrap to.
    always_comb begin
        scan_mask = mask_q;
        scan_from = idx_q + 4'd1;
        if (state_q == IDLE) begin
            scan_mask = bus.pd_mask_i;
            scan_from = 4'd0;
        end
        {hit, hit_idx} = first_set(scan_mask, scan_from);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values,
            // independent of the order the always_ff blocks are evaluated in.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_d
        // unassigned, which would infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_i && !bus.abort_i) state_d = hit ? RST : DONE;
            RST:     if (phase_cnt_q == RST_LAST) state_d = INT;
            INT:     if (phase_cnt_q == int_last) state_d = SAMPLE;
            SAMPLE:  if (phase_cnt_q == SH_LAST) state_d = CONV;
            CONV:    if (bus.cmp_i || (conv_cnt_q == CNT_MAX)) state_d = OUT;
            OUT:     state_d = NEXT;
            NEXT:    state_d = hit ? RST : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.abort_i && (state_q != IDLE)) state_d = IDLE;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            phase_cnt_q <= 16'd0;
            conv_cnt_q  <= '0;
            data_q      <= '0;
            idx_q       <= 4'd0;
            mask_q      <= 12'd0;
            t_int_q     <= 16'd0;
        end else begin
            if ((state_d != state_q) || (state_q == IDLE)) phase_cnt_q <= 16'd0;
            else                                           phase_cnt_q <= phase_cnt_q + 16'd1;

            // Held at zero outside CONV, so it is already cleared on entry.
            if (state_q != CONV)     conv_cnt_q <= '0;
            else if (state_d == CONV) conv_cnt_q <= conv_cnt_q + 1'b1;

            if ((state_q == CONV) && (state_d == OUT))
                data_q <= bus.cmp_i ? conv_cnt_q : CNT_MAX;

            if ((state_q == IDLE) && (state_d != IDLE)) begin
                mask_q  <= bus.pd_mask_i;
                t_int_q <= bus.t_int_i;
                if (hit) idx_q <= hit_idx;
            end

            if ((state_q == NEXT) && (state_d == RST)) idx_q <= hit_idx;
        end
    end

    logic        sw1, sw2, sh, sh_cmp, sh_rst, dv, done, busy;
    logic [11:0] pd_a, pd_b, pd_sel;
    logic [4:0]  tg_sel;

    assign pd_sel = 12'd1 << idx_q;

    always_comb begin
        sw1    = 1'b0;
        sw2    = 1'b0;
        sh     = 1'b0;
        sh_cmp = 1'b0;
        sh_rst = 1'b0;
        dv     = 1'b0;
        done   = 1'b0;
        busy   = (state_q != IDLE);
        pd_a   = 12'd0;
        pd_b   = 12'd0;
        tg_sel = TG_OTA_OUT;
        case (state_q)
            RST: begin
                sh_rst = 1'b1;
                sw1    = 1'b1;
                pd_a   = pd_sel;
                pd_b   = pd_sel;
            end
            INT:    pd_a = pd_sel;
            SAMPLE: begin
                sh     = 1'b1;
                pd_a   = pd_sel;
                tg_sel = TG_OTA_SH;
            end
            CONV: begin
                sh_cmp = 1'b1;
                sw2    = 1'b1;
                tg_sel = TG_VREF_CMP;
            end
            OUT: begin
                dv     = 1'b1;
                tg_sel = TG_CMP_OUT;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign bus.sw1_o        = sw1;
    assign bus.sw2_o        = sw2;
    assign bus.sh_o         = sh;
    assign bus.sh_cmp_o     = sh_cmp;
    assign bus.sh_rst_o     = sh_rst;
    assign bus.pd_a_o       = pd_a;
    assign bus.pd_b_o       = pd_b;
    assign bus.tg_sel_o     = tg_sel;
    assign bus.data_o       = data_q;
    assign bus.pd_idx_o     = idx_q;
    assign bus.data_valid_o = dv;
    assign bus.done_o       = done;
    assign bus.busy_o       = busy;

endmodule

// File: tb/tb_pixel_seq_ctrl.sv
// Directed bench for pixel_seq_ctrl: phase lengths, conversion results, abort,
// zero mask, zero integration time and asynchronous reset mid-scan.
module tb_pixel_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pixel_seq_ctrl_if #(.CNT_W(8)) bus ();

    pixel_seq_ctrl #(
        .T_RST(4),
        .T_SH (2),
        .CNT_W(8)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    int cyc, rst_cyc, int_cyc, sh_cyc, conv_cyc, busy_cyc, dv_cnt, done_cnt, out_cyc, done_cyc;
    logic [7:0] dv_data [16];
    logic [3:0] dv_idx  [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        rst_cyc = 0; int_cyc = 0; sh_cyc = 0; conv_cyc = 0; busy_cyc = 0;
        dv_cnt = 0; done_cnt = 0; out_cyc = 0; done_cyc = 0;
        for (int i = 0; i < 16; i++) begin
            dv_data[i] = 8'hxx;
            dv_idx[i]  = 4'hx;
        end
    endtask

    // Advance one clock, sample 1 ns after the edge, check invariants, log events.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check("tg_onehot", 32'($onehot(bus.tg_sel_o)), 32'd1);
        check("pd_a_max1", 32'($countones(bus.pd_a_o) <= 1), 32'd1);
        check("pd_b_max1", 32'($countones(bus.pd_b_o) <= 1), 32'd1);
        if (bus.sh_rst_o) rst_cyc++;
        if ((bus.pd_a_o != 12'd0) && (bus.pd_b_o == 12'd0) && !bus.sh_o) int_cyc++;
        if (bus.sh_o) sh_cyc++;
        if (bus.sh_cmp_o) conv_cyc++;
        if (bus.busy_o) busy_cyc++;
        if (bus.data_valid_o) begin
            if (dv_cnt < 16) begin
                dv_data[dv_cnt] = bus.data_o;
                dv_idx[dv_cnt]  = bus.pd_idx_o;
            end
            dv_cnt++;
            out_cyc = cyc;
        end
        if (bus.done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    // Start a scan and run it to IDLE. cmp_i rises in CONV cycle cmp_at of each
    // pixel (0 = never). The mask/t_int inputs are scrambled after start to prove latching.
    task automatic run_scan(input logic [11:0] mask, input logic [15:0] tint,
                            input int cmp_at, input bit start_in_int, input int budget);
        int k, n;
        bit pulsed;
        clear_stats();
        bus.pd_mask_i = mask;
        bus.t_int_i   = tint;
        bus.start_i   = 1'b1;
        tick();
        bus.start_i   = 1'b0;
        bus.pd_mask_i = 12'hFFF;
        bus.t_int_i   = 16'd7;
        k = 0; n = 0; pulsed = 1'b0;
        while (bus.busy_o && (n < budget)) begin
            if (bus.sh_cmp_o) begin
                k++;
                bus.cmp_i = (k == cmp_at);
            end else begin
                k = 0;
                bus.cmp_i = 1'b0;
            end
            bus.start_i = 1'b0;
            if (start_in_int && !pulsed && (bus.pd_a_o != 0) && (bus.pd_b_o == 0) && !bus.sh_o) begin
                bus.start_i = 1'b1;
                pulsed = 1'b1;
            end
            tick();
            n++;
        end
        bus.cmp_i   = 1'b0;
        bus.start_i = 1'b0;
        check("scan_timeout", 32'(n < budget), 32'd1);
    endtask

    int n;

    initial begin
        bus.start_i   = 1'b0;
        bus.abort_i   = 1'b0;
        bus.pd_mask_i = 12'd0;
        bus.t_int_i   = 16'd0;
        bus.cmp_i     = 1'b0;
        cyc = 0;
        clear_stats();

        tick();
        tick();
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_data", 32'(bus.data_o), 32'd0);
        check("rst_idx",  32'(bus.pd_idx_o), 32'd0);
        check("rst_tg",   32'(bus.tg_sel_o), 32'h01);
        check("rst_ctrl", 32'({bus.sw1_o, bus.sw2_o, bus.sh_o, bus.sh_cmp_o, bus.sh_rst_o,
                               bus.data_valid_o, bus.done_o}), 32'd0);
        check("rst_pd",   32'({bus.pd_a_o, bus.pd_b_o}), 32'd0);
        rst = 1'b0;
        tick();

        // Single pixel, cmp in 6th CONV cycle.
        run_scan(12'h001, 16'd10, 6, 1'b0, 500);
        check("s1_rst_len",  32'(rst_cyc), 32'd4);
        check("s1_int_len",  32'(int_cyc), 32'd10);
        check("s1_sh_len",   32'(sh_cyc), 32'd2);
        check("s1_conv_len", 32'(conv_cyc), 32'd6);
        check("s1_dv_cnt",   32'(dv_cnt), 32'd1);
        check("s1_data",     32'(dv_data[0]), 32'd5);
        check("s1_idx",      32'(dv_idx[0]), 32'd0);
        check("s1_done_cnt", 32'(done_cnt), 32'd1);
        check("s1_done_lat", 32'(done_cyc - out_cyc), 32'd2);
        check("s1_busy_len", 32'(busy_cyc), 32'd25);

        // First and last photodiode, comparator never fires: saturation.
        run_scan(12'h801, 16'd3, 0, 1'b0, 2000);
        check("s2_dv_cnt",   32'(dv_cnt), 32'd2);
        check("s2_idx0",     32'(dv_idx[0]), 32'd0);
        check("s2_idx1",     32'(dv_idx[1]), 32'd11);
        check("s2_data0",    32'(dv_data[0]), 32'd255);
        check("s2_data1",    32'(dv_data[1]), 32'd255);
        check("s2_conv_len", 32'(conv_cyc), 32'd512);
        check("s2_int_len",  32'(int_cyc), 32'd6);
        check("s2_done_cnt", 32'(done_cnt), 32'd1);

        // Empty mask: straight to DONE.
        run_scan(12'h000, 16'd5, 0, 1'b0, 50);
        check("s3_done_cnt", 32'(done_cnt), 32'd1);
        check("s3_dv_cnt",   32'(dv_cnt), 32'd0);
        check("s3_busy_len", 32'(busy_cyc), 32'd1);
        check("s3_data_hold", 32'(bus.data_o), 32'd255);

        // abort and start together in IDLE.
        clear_stats();
        bus.pd_mask_i = 12'h001;
        bus.start_i   = 1'b1;
        bus.abort_i   = 1'b1;
        tick();
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        tick();
        check("idle_abort_busy", 32'(busy_cyc), 32'd0);
        check("idle_abort_done", 32'(done_cnt), 32'd0);

        // Abort during CONV of pixel 3 of a full mask.
        clear_stats();
        bus.pd_mask_i = 12'hFFF;
        bus.t_int_i   = 16'd1;
        bus.start_i   = 1'b1;
        tick();
        bus.start_i = 1'b0;
        n = 0;
        while (!(bus.sh_cmp_o && (bus.pd_idx_o == 4'd3)) && (n < 2000)) begin
            bus.cmp_i = bus.sh_cmp_o;
            tick();
            n++;
        end
        check("s4_reach_conv3", 32'(n < 2000), 32'd1);
        bus.cmp_i   = 1'b0;
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        check("s4_busy",  32'(bus.busy_o), 32'd0);
        check("s4_pd",    32'({bus.pd_a_o, bus.pd_b_o}), 32'd0);
        check("s4_tg",    32'(bus.tg_sel_o), 32'h01);
        check("s4_sw2",   32'(bus.sw2_o), 32'd0);
        repeat (3) tick();
        check("s4_dv_cnt",   32'(dv_cnt), 32'd3);
        check("s4_done_cnt", 32'(done_cnt), 32'd0);
        run_scan(12'h00F, 16'd1, 1, 1'b0, 500);
        check("s4_new_dv",   32'(dv_cnt), 32'd4);
        check("s4_new_idx0", 32'(dv_idx[0]), 32'd0);
        check("s4_new_idx3", 32'(dv_idx[3]), 32'd3);
        check("s4_new_data", 32'(dv_data[0]), 32'd0);
        check("s4_new_done", 32'(done_cnt), 32'd1);

        // Zero integration time, start pulsed during INT is ignored.
        run_scan(12'h004, 16'd0, 3, 1'b1, 500);
        check("s5_int_len",  32'(int_cyc), 32'd1);
        check("s5_dv_cnt",   32'(dv_cnt), 32'd1);
        check("s5_idx",      32'(dv_idx[0]), 32'd2);
        check("s5_data",     32'(dv_data[0]), 32'd2);
        check("s5_done_cnt", 32'(done_cnt), 32'd1);
        check("s5_busy_len", 32'(busy_cyc), 32'd13);

        // Asynchronous reset in the middle of SAMPLE.
        clear_stats();
        bus.pd_mask_i = 12'h001;
        bus.t_int_i   = 16'd2;
        bus.start_i   = 1'b1;
        tick();
        bus.start_i = 1'b0;
        n = 0;
        while (!bus.sh_o && (n < 100)) begin
            tick();
            n++;
        end
        check("s6_reach_sample", 32'(n < 100), 32'd1);
        check("s6_data_hold",    32'(bus.data_o), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("s6_async_sh",   32'(bus.sh_o), 32'd0);
        check("s6_async_busy", 32'(bus.busy_o), 32'd0);
        check("s6_async_pd",   32'(bus.pd_a_o), 32'd0);
        check("s6_async_tg",   32'(bus.tg_sel_o), 32'h01);
        check("s6_async_data", 32'(bus.data_o), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("s6_no_done", 32'(done_cnt), 32'd0);
        run_scan(12'h010, 16'd5, 2, 1'b0, 500);
        check("s6_new_dv",   32'(dv_cnt), 32'd1);
        check("s6_new_idx",  32'(dv_idx[0]), 32'd4);
        check("s6_new_data", 32'(dv_data[0]), 32'd1);
        check("s6_new_done", 32'(done_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pixel_seq_ctrl.md
PIXEL_SEQ_CTRL -- requirements
Module: pixel_seq_ctrl

Interface
REQ-001 SHALL have parameter T_RST, default 4: pixel reset phase length, clock cycles, 1..255.
REQ-002 SHALL have parameter T_SH, default 2: sample-and-hold phase length, clock cycles, 1..255.
REQ-003 SHALL have parameter CNT_W, default 8: conversion counter width.
REQ-004 SHALL have port wb_clk_i, input, 1: the block's single clock; all logic is on the rising edge.
REQ-005 SHALL have port wb_rst_i, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port start_i, input, 1: one-cycle request to start a frame scan.
REQ-007 SHALL have port abort_i, input, 1: level request to stop the scan immediately.
REQ-008 SHALL have port pd_mask_i, input, 12: enable mask for photodiodes 1..12 (bit 0 = PD1); sampled at start.
REQ-009 SHALL have port t_int_i, input, 16: integration length in cycles; sampled at start; 0 is treated as 1.
REQ-010 SHALL have port cmp_i, input, 1: comparator decision from the analog macro; treated as already synchronous.
REQ-011 SHALL have ports sw1_o, sw2_o, sh_o, sh_cmp_o and sh_rst_o, each output, 1: analog switch controls.
REQ-012 SHALL have ports pd_a_o and pd_b_o, each output, 12: per-photodiode select pairs.
REQ-013 SHALL have port tg_sel_o, output, 5: one-hot TGate select; [0] OTA_out, [1] SH_out, [2] CMP_out, [3] OTA_sh, [4] Vref_cmp.
REQ-014 SHALL have port data_o, output, CNT_W: last conversion result.
REQ-015 SHALL have port pd_idx_o, output, 4: index 0..11 of the pixel being processed.
REQ-016 SHALL have ports data_valid_o, done_o and busy_o, each output, 1: result strobe, frame-complete pulse and scan-active flag.

Function
REQ-017 SHALL implement the states IDLE, RST, INT, SAMPLE, CONV, OUT, NEXT and DONE; busy_o SHALL be 1 in every state except IDLE.
REQ-018 IDLE + start_i: SHALL latch pd_mask_i and t_int_i, then go to RST at the lowest set mask bit; if the mask is zero, SHALL go to DONE.
REQ-019 RST (T_RST cycles): sh_rst_o=1, sw1_o=1, pd_a_o[idx]=1, pd_b_o[idx]=1, tg_sel_o=00001; then go to INT.
REQ-020 INT (latched t_int cycles): pd_a_o[idx]=1, pd_b_o=0, tg_sel_o=00001; then go to SAMPLE.
REQ-021 SAMPLE (T_SH cycles): sh_o=1, pd_a_o[idx]=1, tg_sel_o=01000; then go to CONV.
REQ-022 CONV: sh_cmp_o=1, sw2_o=1, tg_sel_o=10000; the counter SHALL be cleared to 0 on entry to CONV.
REQ-023 CONV, each cycle: if cmp_i=1, data_o SHALL take the counter value and the state goes to OUT; else if counter = 2^CNT_W-1, data_o SHALL take 2^CNT_W-1 (saturate) and the state goes to OUT; else counter+1.
REQ-024 cmp_i=1 in the first CONV cycle SHALL give data_o=0.
REQ-025 OUT (1 cycle): data_valid_o=1, tg_sel_o=00100; data_o and pd_idx_o SHALL be stable; then go to NEXT.
REQ-026 NEXT (1 cycle): SHALL advance to the next higher set mask bit and go to RST; if there is none, SHALL go to DONE; index 11 SHALL never wrap to 0.
REQ-027 DONE (1 cycle): done_o=1; then go to IDLE.
REQ-028 Outputs not named for a state SHALL be 0, except tg_sel_o, which is 00001.
REQ-029 pd_a_o and pd_b_o SHALL never have more than one bit set.
REQ-030 tg_sel_o SHALL always be exactly one-hot.
REQ-031 data_o SHALL hold its value between OUT strobes.
REQ-032 start_i while busy_o=1 SHALL be ignored.
REQ-033 abort_i=1 in any state other than IDLE SHALL force IDLE on the next edge, with no data_valid_o and no done_o.
REQ-034 abort_i has priority over every other transition; abort_i and start_i together in IDLE SHALL leave the block in IDLE.
REQ-035 Phase counters SHALL be 16 bits; phase lengths SHALL be exact, with no off-by-one.

Reset
REQ-036 On wb_rst_i=1, the state SHALL be IDLE, all counters and the index 0, data_o=0, all control outputs 0 and tg_sel_o=00001.
REQ-037 Reset asserted mid-scan SHALL abort the scan; no done_o SHALL follow.
REQ-038 After reset deasserts, the first accepted start_i SHALL begin a fresh scan.

Verification
REQ-039 mask=0x001, t_int=10, cmp_i rises in the 6th CONV cycle -> RST 4 cycles, INT 10, SAMPLE 2; data_o=5, pd_idx_o=0; done_o one cycle after NEXT.
REQ-040 mask=0x801, cmp_i held 0 -> two results, idx 0 then 11, both data_o=255; exactly one done_o.
REQ-041 mask=0x000, start_i -> done_o on the 2nd cycle after start; no data_valid_o; busy_o high for 1 cycle.
REQ-042 abort_i during CONV of idx 3 (mask=0xFFF) -> IDLE next cycle; all pd bits 0; no done_o; a new start_i scans from idx 0.
REQ-043 t_int=0 -> INT lasts 1 cycle; start_i pulsed during INT -> ignored.
REQ-044 wb_rst_i asserted asynchronously mid-SAMPLE -> outputs reach their reset values without waiting for a clock edge; data_o=0.
